// File: rtl/npu_iob_pkg.sv
// Shared types for the IO-buffer read arbiter: buffer geometry and the return-path tag.
// Id width is sized for the largest supported requester count so one type serves every build.
package npu_iob_pkg;

    localparam int IOB_ADDR_W  = 13;
    localparam int IOB_DATA_W  = 64;
    localparam int IOB_MAX_REQ = 8;

    typedef logic [$clog2(IOB_MAX_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: grants the first requester after rr_ptr, wrapping
// modulo NUM_REQ, and returns both the one-hot grant and its encoded id.
module iob_rr_pick
    import npu_iob_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int               sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        // Lowest offset from the pointer wins, so the last winner is checked last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = int'(rr_ptr) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = req_id_t'(sum);
            end
        end
    end

endmodule

// File: rtl/iob_read_arbiter.sv
// Round-robin arbiter sharing the IO-buffer read port, with a tagged return path.
// Define IOB_ARB_BURST_EN to add i_lock, which lets a requester hold the port for a burst.
module iob_read_arbiter
    import npu_iob_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = IOB_ADDR_W,
    parameter int DATA_W  = IOB_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
`ifdef IOB_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]        i_lock,
`endif
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_rd_en,
    output logic [ADDR_W-1:0]         o_d_addr,
    input  logic [DATA_W-1:0]         i_rdata,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata
);

    req_id_t                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      pick_gnt, gnt;
    req_id_t                 pick_id, gnt_id;
    logic                    xfer;
    logic [ADDR_W-1:0]       addr_sel;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       d_addr_q, d_addr_d;
    tag_t [RD_LAT-1:0]       tag_q, tag_d;
    tag_t                    tag_out;
    logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    iob_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (i_req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .id     (pick_id)
    );

`ifdef IOB_ARB_BURST_EN
    logic    lock_vld_q, lock_vld_d;
    req_id_t lock_owner_q, lock_owner_d;
    logic    owner_req;

    always_comb begin
        owner_req = |(i_req & (NUM_REQ'(1) << lock_owner_q));
        gnt       = pick_gnt;
        gnt_id    = pick_id;
        if (lock_vld_q && owner_req) begin
            gnt    = NUM_REQ'(1) << lock_owner_q;
            gnt_id = lock_owner_q;
        end
    end

    // Every transfer re-decides the lock; the owner dropping its request also releases it.
    always_comb begin
        lock_vld_d   = lock_vld_q && owner_req;
        lock_owner_d = lock_owner_q;
        if (xfer) begin
            lock_vld_d   = |(i_lock & o_gnt);
            lock_owner_d = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    always_comb begin
        gnt    = pick_gnt;
        gnt_id = pick_id;
    end
`endif

    assign o_gnt = rst ? '0 : gnt;
    assign xfer  = |(i_req & o_gnt);

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_gnt[i]) begin
                addr_sel = addr_sel | i_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

    always_comb begin
        rr_ptr_d  = xfer ? gnt_id : rr_ptr_q;
        rd_en_d   = xfer;
        d_addr_d  = xfer ? addr_sel : d_addr_q;
        tag_d[0]  = '{vld: xfer, id: gnt_id};
        for (int s = 1; s < RD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        rvalid_d = tag_out.vld ? (NUM_REQ'(1) << tag_out.id) : '0;
        rdata_d  = tag_out.vld ? i_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= req_id_t'(NUM_REQ - 1);
            rd_en_q  <= 1'b0;
            d_addr_q <= '0;
            tag_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rd_en_q  <= rd_en_d;
            d_addr_q <= d_addr_d;
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_rd_en  = rd_en_q;
    assign o_d_addr = d_addr_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;

endmodule
